// File: rtl/ones_stream_gen.sv
// Serial frame generator: emits FRAME_LEN bits on data holding exactly min(req_count, FRAME_LEN) ones.
// Latency: first frame bit appears the cycle after a request is accepted; GAP_CYCLES idle cycles follow each frame.
// Backpressure: req_ready is high only in IDLE; requests presented while busy are ignored (no queue).
module ones_stream_gen #(
  parameter int CNT_W      = 4,
  parameter int FRAME_LEN  = 15,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [1:0]       req_mode,
  output logic             data,
  output logic             data_en,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] sent_count,
  output logic             busy,
  output logic             err_clamp
);

  // Frame length and last bit index expressed at the count width.
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  // Gap counter sizing; the GAP state is unreachable when GAP_CYCLES is 0.
  localparam int GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_INT);

  localparam logic [1:0] MODE_FIRST = 2'd0;
  localparam logic [1:0] MODE_LAST  = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Datapath registers. pos is the index of the bit currently on data;
  // ones_left is the number of ones still owed after that bit.
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] ones_left;
  logic [1:0]       mode_q;
  logic             data_q;
  logic [CNT_W-1:0] sent_q;
  logic             err_q;
  logic [GAP_W-1:0] gap_cnt;

  // Bit-rule operands and result for the bit that will be driven next cycle.
  logic             accept;
  logic [CNT_W-1:0] k_clamp;
  logic [CNT_W-1:0] rule_k;
  logic [CNT_W-1:0] rule_r;
  logic [1:0]       rule_mode;
  logic             rule_prev;
  logic             nxt_bit;
  logic             last_bit;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> SEND on accept, SEND -> GAP/IDLE after the last bit, GAP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (last_bit) begin
          state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and bit-rule decode from the current state and datapath registers.
  always_comb begin
    req_ready   = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    data_en     = (state == ST_SEND);
    data        = data_q & data_en;
    last_bit    = data_en && (pos == LAST);
    frame_start = data_en && (pos == '0);
    frame_done  = last_bit;
    sent_count  = sent_q;
    err_clamp   = err_q;

    accept  = req_valid && req_ready;
    k_clamp = (req_count > LEN) ? LEN : req_count;

    // In IDLE the next bit is bit 0 of a new frame: nothing precedes it, so prev reads as 0.
    if (state == ST_IDLE) begin
      rule_k    = k_clamp;
      rule_r    = LEN;
      rule_mode = req_mode;
      rule_prev = 1'b0;
    end else begin
      rule_k    = ones_left;
      rule_r    = LAST - pos;
      rule_mode = mode_q;
      rule_prev = data_q;
    end

    // Forced cases first guarantee the exact ones count; the mode only decides when there is slack.
    if (rule_k == '0) begin
      nxt_bit = 1'b0;
    end else if (rule_k == rule_r) begin
      nxt_bit = 1'b1;
    end else begin
      case (rule_mode)
        MODE_LAST: nxt_bit = 1'b0;
        MODE_ALT:  nxt_bit = ~rule_prev;
        default:   nxt_bit = 1'b1;
      endcase
    end
  end

  // Frame datapath: latch the request on accept, then shift out one rule-derived bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos       <= '0;
      ones_left <= '0;
      mode_q    <= MODE_FIRST;
      data_q    <= 1'b0;
      sent_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        pos       <= '0;
        mode_q    <= (req_mode == 2'd3) ? MODE_FIRST : req_mode;
        data_q    <= nxt_bit;
        ones_left <= k_clamp - CNT_W'(nxt_bit);
        sent_q    <= CNT_W'(nxt_bit);
        err_q     <= (req_count > LEN);
      end else if (data_en) begin
        if (last_bit) begin
          data_q <= 1'b0;
        end else begin
          pos       <= pos + CNT_W'(1);
          data_q    <= nxt_bit;
          ones_left <= ones_left - CNT_W'(nxt_bit);
          sent_q    <= sent_q + CNT_W'(nxt_bit);
        end
      end
    end
  end

  // Gap counter: cleared while sending, counts idle cycles while in GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

endmodule
